// File: rtl/instruction_controller_pkg.sv
// instruction_controller_pkg: shared states, ISA field codes, writeback and ALU encodings
package instruction_controller_pkg;
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_OPERATE, S_WRITE_REG, S_WRITE_IMM
  } state_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] VSEL_C = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;
endpackage

// File: rtl/instruction_controller_decoder.sv
// instr_decoder: splits the instruction register into fields, sign-extends immediates, classifies the op
module instr_decoder
  import instruction_controller_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        legal,
  output logic        mov_imm,
  output logic        needs_a,
  output logic        cmp,
  output logic [1:0]  alu_op
);
  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_alu;
  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign sh      = ir[4:3];
  assign rm      = ir[2:0];
  assign sximm8  = {{8{ir[7]}}, ir[7:0]};
  assign sximm5  = {{11{ir[4]}}, ir[4:0]};
  assign is_alu  = opcode == OPC_ALU;
  assign mov_imm = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign legal   = is_alu || mov_imm || (opcode == OPC_MOV && op == OP_MOV_REG);
  assign needs_a = is_alu && op != OP_MVN;
  assign cmp     = is_alu && op == OP_CMP;
  assign alu_op  = !is_alu ? ALU_ADD :
                   op == OP_ADD ? ALU_ADD :
                   op == OP_CMP ? ALU_SUB :
                   op == OP_AND ? ALU_AND : ALU_NOT;
endmodule

// File: rtl/instruction_controller.sv
// instruction_controller: multi-cycle Moore FSM sequencing register-file/ALU datapath strobes
module instruction_controller
  import instruction_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        done,
  output logic        err
);
  state_t      state, next;
  logic [15:0] ir;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh, alu_op;
  logic        legal, mov_imm, needs_a, cmp;

  instr_decoder u_dec (
    .ir(ir), .rn(rn), .rd(rd), .rm(rm), .sh(sh),
    .sximm8(sximm8), .sximm5(sximm5),
    .legal(legal), .mov_imm(mov_imm), .needs_a(needs_a), .cmp(cmp), .alu_op(alu_op)
  );

  // state register and instruction latch, loaded only on an accepted handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && in_valid) ir <= instr;
    end
  end

  // next-state: route by instruction class, illegal ops fall straight back to WAIT
  always_comb begin
    next = S_WAIT;
    case (state)
      S_WAIT:    next = in_valid ? S_DECODE : S_WAIT;
      S_DECODE:  next = !legal ? S_WAIT : mov_imm ? S_WRITE_IMM : needs_a ? S_GET_A : S_GET_B;
      S_GET_A:   next = S_GET_B;
      S_GET_B:   next = S_OPERATE;
      S_OPERATE: next = cmp ? S_WAIT : S_WRITE_REG;
      default:   next = S_WAIT;
    endcase
  end

  assign in_ready = state == S_WAIT;
  assign readnum  = state == S_GET_A ? rn : state == S_GET_B ? rm : 3'd0;
  assign writenum = state == S_WRITE_REG ? rd : state == S_WRITE_IMM ? rn : 3'd0;
  assign loada    = state == S_GET_A;
  assign loadb    = state == S_GET_B;
  assign loadc    = state == S_OPERATE && !cmp;
  assign loads    = state == S_OPERATE && cmp;
  assign write    = state == S_WRITE_REG || state == S_WRITE_IMM;
  assign asel     = state == S_OPERATE && needs_a;
  assign bsel     = 1'b0;
  assign vsel     = state == S_WRITE_IMM ? VSEL_IMM8 : VSEL_C;
  assign shift    = state == S_OPERATE ? sh : 2'd0;
  assign ALUop    = state == S_OPERATE ? alu_op : 2'd0;
  assign done     = write || (state == S_OPERATE && cmp);
  assign err      = state == S_DECODE && !legal;
endmodule

// File: tb/tb_instruction_controller.sv
// tb_instruction_controller: randomized instruction stream checked against a per-instruction cycle model
module tb_instruction_controller;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        in_valid = 0;
  logic [15:0] instr = '0;
  logic        in_ready, loada, loadb, loadc, loads, write, asel, bsel, done, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic [15:0] ir_m = '0;
  logic [21:0] q[$];
  int          checks = 0;
  int          errors = 0;

  instruction_controller dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .write(write), .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
    .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] vec(logic rdy, logic [2:0] rnum, logic [2:0] wnum,
      logic la, logic lb, logic lc, logic ls, logic wr, logic as, logic bs,
      logic [1:0] vs, logic [1:0] sh, logic [1:0] alu, logic dn, logic er);
    return {rdy, rnum, wnum, la, lb, lc, ls, wr, as, bs, vs, sh, alu, dn, er};
  endfunction

  localparam logic [21:0] WAITV = 22'h200000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_check(input string tag, input logic [21:0] e);
    check(tag, {10'd0, in_ready, readnum, writenum, loada, loadb, loadc, loads, write,
                asel, bsel, vsel, shift, ALUop, done, err}, {10'd0, e});
    check({tag, "_imm"}, {sximm8, sximm5},
          {{{8{ir_m[7]}}, ir_m[7:0]}, {{11{ir_m[4]}}, ir_m[4:0]}});
  endtask

  // expected output vector for every cycle from DECODE through the done/err cycle
  task automatic build(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh, code;
    logic       mov_imm, mov_reg, alu, legal, two_src, is_cmp;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    mov_imm = opc == 3'b110 && op == 2'b10;
    mov_reg = opc == 3'b110 && op == 2'b00;
    alu     = opc == 3'b101;
    legal   = mov_imm || mov_reg || alu;
    two_src = alu && op != 2'b11;
    is_cmp  = alu && op == 2'b01;
    code    = !alu ? 2'd0 : op == 2'b01 ? 2'd1 : op == 2'b10 ? 2'd2 : op == 2'b11 ? 2'd3 : 2'd0;
    q.delete();
    q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !legal));
    if (!legal) return;
    if (mov_imm) begin
      q.push_back(vec(0, 0, rn, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 1, 0));
      return;
    end
    if (two_src) q.push_back(vec(0, rn, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(vec(0, rm, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(vec(0, 0, 0, 0, 0, !is_cmp, is_cmp, 0, two_src, 0, 0, sh, code, is_cmp, 0));
    if (!is_cmp) q.push_back(vec(0, 0, rd, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
  endtask

  // called #1 after an edge with the DUT in WAIT; returns #1 after the edge ending the last cycle
  task automatic run_instr(input string tag, input logic [15:0] ins, input bit idle, input int abort_at);
    step_check({tag, "_wait"}, WAITV);
    if (idle) begin
      in_valid = 0;
      instr = 16'($urandom);
      @(posedge clk); #1;
      step_check({tag, "_idle"}, WAITV);
    end
    in_valid = 1;
    instr = ins;
    @(posedge clk); #1;
    ir_m = ins;
    build(ins);
    foreach (q[i]) begin
      step_check($sformatf("%s_c%0d", tag, i + 1), q[i]);
      in_valid = $urandom_range(0, 3) != 0;
      instr = 16'($urandom);
      if (i == abort_at) begin
        reset_n = 0;
        @(posedge clk); #1;
        ir_m = '0;
        reset_n = 1;
        step_check({tag, "_abort"}, WAITV);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    int r;
    v = 16'($urandom);
    r = $urandom_range(0, 3);
    v[15:13] = r == 0 ? 3'b110 : r == 3 ? 3'($urandom) : 3'b101;
    return v;
  endfunction

  initial begin
    in_valid = 1;
    instr = 16'hD0FB;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    in_valid = 0;
    step_check("reset", WAITV);
    run_instr("movimm", 16'hD0FB, 0, -1);
    run_instr("add", 16'hA1A8, 1, -1);
    run_instr("cmp", 16'hAA01, 0, -1);
    run_instr("illegal", 16'hE000, 0, -1);
    run_instr("abort_add", 16'hA1A8, 0, 3);
    run_instr("mvn", 16'hB8E1, 0, -1);
    run_instr("b2b_mov", 16'hD37F, 0, -1);
    for (int n = 0; n < 300; n++)
      run_instr($sformatf("rnd%0d", n), rand_instr(), $urandom_range(0, 4) == 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_controller.md
INSTRUCTION_CONTROLLER -- requirements
Module: instruction_controller

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low, with ports named clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  instruction on instr is offered.
REQ-005 instr  input  16  instruction word: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
REQ-006 in_ready  output  1  controller idle; instruction accepted when in_valid & in_ready.
REQ-007 readnum, writenum  output  3 each  register-file read and write indices.
REQ-008 loada, loadb, loadc, loads, write  output  1 each  datapath load and write strobes.
REQ-009 asel, bsel  output  1 each  asel=1 selects A (0 selects zero); bsel=1 selects sximm5 (0 selects shifted B).
REQ-010 vsel  output  2  writeback source: 00=C, 01=sximm8, 10/11 reserved (driven 00).
REQ-011 shift, ALUop  output  2 each  shifter and ALU controls for the computation stage.
REQ-012 sximm8, sximm5  output  16 each  sign-extended imm8 and imm5 of the latched instruction.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 err  output  1  one-cycle pulse when an illegal instruction is dropped.

Function
REQ-015 States SHALL be: WAIT, DECODE, GET_A, GET_B, OPERATE, WRITE_REG, WRITE_IMM.
REQ-016 in_ready SHALL be 1 only in WAIT.
REQ-017 On accept, the block SHALL latch instr into the 16-bit instruction register (IR) and go WAIT->DECODE.
REQ-018 The ISA SHALL be:
- 110/10 MOV Rn,#imm8
- 110/00 MOV Rd,Rm,sh
- 101/00 ADD Rd,Rn,Rm,sh
- 101/01 CMP Rn,Rm,sh
- 101/10 AND Rd,Rn,Rm,sh
- 101/11 MVN Rd,Rm,sh
REQ-019 Transitions out of DECODE SHALL be:
- MOV imm -> WRITE_IMM
- MOV reg and MVN -> GET_B
- ADD, CMP and AND -> GET_A
- any other opcode/op -> WAIT with err=1 for that cycle
REQ-020 GET_A SHALL drive readnum=Rn and loada=1, then go to GET_B.
REQ-021 GET_B SHALL drive readnum=Rm and loadb=1, then go to OPERATE.
REQ-022 OPERATE SHALL drive shift=sh and bsel=0, with:
- asel=0 for MOV reg and MVN, asel=1 otherwise
- ALUop: MOV reg 00, ADD 00, CMP 01, AND 10, MVN 11
- loadc=1 except CMP
- loads=1 only for CMP
REQ-023 From OPERATE the block SHALL go to WAIT with done=1 for CMP, and to WRITE_REG otherwise.
REQ-024 WRITE_REG SHALL drive vsel=00, writenum=Rd and write=1, with done=1, then go to WAIT.
REQ-025 WRITE_IMM SHALL drive vsel=01, writenum=Rn and write=1, with done=1, then go to WAIT.
REQ-026 Outputs SHALL be Moore functions of state and IR; every strobe not named for a state SHALL be 0, and readnum, writenum, shift and ALUop SHALL be 0 there.
REQ-027 Latency from the accept edge to the done cycle SHALL be:
- MOV imm: 2 cycles
- CMP: 4 cycles
- MOV reg and MVN: 4 cycles
- ADD and AND: 5 cycles
REQ-028 sximm8 SHALL equal {8{IR[7]}},IR[7:0], and sximm5 SHALL equal {11{IR[4]}},IR[4:0], at all times.
REQ-029 in_valid outside WAIT SHALL be ignored; instr changes mid-execution SHALL have no effect.
REQ-030 Back-to-back operation: the instruction offered in the cycle after done SHALL be accepted, giving no dead cycle beyond WAIT.

Reset
REQ-031 While reset_n=0 at a clk edge, the block SHALL set state=WAIT and IR=0; all strobes, done and err SHALL then be 0 and in_ready=1.
REQ-032 Reset mid-instruction SHALL abort it with no write, loadc or loads asserted in the following cycle.

Structure
REQ-033 A shared package SHALL hold the state enum, the opcode/op constants, the vsel encodings and the ALUop encodings.
REQ-034 One combinational sub-module, instr_decoder, SHALL extract the IR fields, sign-extend the immediates, and flag legal instructions.
REQ-035 The implementation SHALL be a single state register plus IR, with no other storage.

Verification
REQ-036 MOV imm: instr=16'hD0FB (MOV R0,#-5) -> WRITE_IMM 2 cycles after accept, with writenum=0, vsel=01, sximm8=16'hFFFB, write=1 and done=1.
REQ-037 ADD: instr=16'hA1A8 (ADD R5,R1,R0,LSL#1) -> GET_A readnum=1; GET_B readnum=0; OPERATE ALUop=00, shift=01, asel=1, loadc=1; WRITE_REG writenum=5, done at +5.
REQ-038 CMP: instr=16'hAA01 (CMP R2,R1) -> OPERATE ALUop=01, loads=1, loadc=0; no write; done at +4.
REQ-039 Illegal: instr=16'hE000 -> err=1 in DECODE, back in WAIT next cycle, no strobes asserted.
REQ-040 Reset in OPERATE of an ADD -> state WAIT, write=0, in_ready=1 after that edge.
REQ-041 Back-to-back MVN then MOV imm with in_valid held -> second accept the cycle after the first done; in_valid asserted during execution is ignored.
